lcd_timing_pattern_gen: RTL and testbench

LCD_TIMING_PATTERN_GEN -- requirements
Module: lcd_timing_pattern_gen

---
 rtl/lcd_timing_pattern_gen.sv | 243 ++++++++++++++++++++++++
 tb/tb_lcd_timing_pattern_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_pattern_gen.sv
// LCD raster timing generator with built-in test patterns (bars, ramp, checker, scrolling XOR, border).
// Latency 1 clk counters->outputs; no backpressure, en=0 parks the raster at (0,0) with blanked outputs.
module lcd_timing_pattern_gen #(
    parameter int H_ACTIVE   = 1366,
    parameter int H_FP       = 48,
    parameter int H_SYNC     = 32,
    parameter int H_BP       = 89,
    parameter int V_ACTIVE   = 768,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 4,
    parameter bit SYNC_POL   = 1'b0,
    parameter int COLOR_BITS = 6,
    parameter int CNT_W      = 12,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [2:0]                pattern_sel,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic [COLOR_BITS-1:0]     red,
    output logic [COLOR_BITS-1:0]     green,
    output logic [COLOR_BITS-1:0]     blue,
    output logic [CNT_W-1:0]          pos_x,
    output logic [CNT_W-1:0]          pos_y,
    output logic [7:0]                frame_cnt,
    output logic                      frame_start,
    output logic [3*COLOR_BITS+2:0]   video_data
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] H_ACT_C      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_ACT_LAST_C = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_SS_C       = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE_C       = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST_C     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_LAST_C = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_SS_C       = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE_C       = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST_C     = CNT_W'(V_TOTAL - 1);

    localparam logic SYNC_ACT  = SYNC_POL;
    localparam logic SYNC_IDLE = ~SYNC_POL;

    localparam logic [COLOR_BITS-1:0] ONES = {COLOR_BITS{1'b1}};

    localparam logic [2:0] PAT_SOLID  = 3'd0;
    localparam logic [2:0] PAT_BARS   = 3'd1;
    localparam logic [2:0] PAT_RAMP   = 3'd2;
    localparam logic [2:0] PAT_CHECK  = 3'd3;
    localparam logic [2:0] PAT_XOR    = 3'd4;
    localparam logic [2:0] PAT_BORDER = 3'd5;

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             h_last;
    logic             v_last;
    logic             at_origin;
    logic             frame_wrap;

    assign h_last     = (h == H_LAST_C);
    assign v_last     = (v == V_LAST_C);
    assign at_origin  = (h == '0) && (v == '0);
    assign frame_wrap = en && h_last && v_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (!en) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Pattern is sampled only at the raster origin so a frame never mixes two patterns.
    logic [2:0] pat_q;
    logic [2:0] pat_cur;
    logic [5:0] scroll;

    assign pat_cur = at_origin ? pattern_sel : pat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q     <= PAT_SOLID;
            scroll    <= '0;
            frame_cnt <= '0;
        end else begin
            if (at_origin) begin
                pat_q <= pattern_sel;
            end
            if (frame_wrap) begin
                scroll    <= scroll - 1'b1;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    logic de_c;
    logic hs_act;
    logic vs_act;

    assign de_c   = (h < H_ACT_C) && (v < V_ACT_C);
    assign hs_act = (h >= H_SS_C) && (h < H_SE_C);
    assign vs_act = (v >= V_SS_C) && (v < V_SE_C);

    // Bar index 8 marks the leftover pixels right of the last full bar.
    logic [3:0] bar_idx;
    logic [2:0] bar_rgb;

    always_comb begin
        bar_idx = 4'd8;
        for (int k = 7; k >= 0; k--) begin
            if (h < CNT_W'((k + 1) * BAR_W)) begin
                bar_idx = 4'(k);
            end
        end
    end

    always_comb begin
        case (bar_idx)
            4'd0:    bar_rgb = 3'b111;
            4'd1:    bar_rgb = 3'b110;
            4'd2:    bar_rgb = 3'b011;
            4'd3:    bar_rgb = 3'b010;
            4'd4:    bar_rgb = 3'b101;
            4'd5:    bar_rgb = 3'b100;
            4'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end

    logic [5:0] xor_a;
    logic [5:0] xor_b;
    logic [5:0] xor_p;
    logic [7:0] xor_p2;
    logic [7:0] xor_p3;
    logic [7:0] xor_p4;

    always_comb begin
        xor_a  = h[5:0] + scroll;
        xor_b  = v[5:0] + scroll;
        xor_p  = xor_a ^ xor_b;
        xor_p2 = {1'b0, xor_p, 1'b0};
        xor_p4 = {xor_p, 2'b00};
        xor_p3 = {2'b00, xor_p} + {1'b0, xor_p, 1'b0};
    end

    logic                  border;
    logic [COLOR_BITS-1:0] r_c;
    logic [COLOR_BITS-1:0] g_c;
    logic [COLOR_BITS-1:0] b_c;

    assign border = (h == '0) || (h == H_ACT_LAST_C) || (v == '0) || (v == V_ACT_LAST_C);

    always_comb begin
        r_c = '0;
        g_c = '0;
        b_c = '0;
        case (pat_cur)
            PAT_SOLID: begin
                r_c = ONES;
            end
            PAT_BARS: begin
                r_c = bar_rgb[2] ? ONES : '0;
                g_c = bar_rgb[1] ? ONES : '0;
                b_c = bar_rgb[0] ? ONES : '0;
            end
            PAT_RAMP: begin
                r_c = h[COLOR_BITS-1:0];
                g_c = h[COLOR_BITS-1:0];
                b_c = h[COLOR_BITS-1:0];
            end
            PAT_CHECK: begin
                if (h[CHECK_LOG2] ^ v[CHECK_LOG2]) begin
                    r_c = ONES;
                    g_c = ONES;
                    b_c = ONES;
                end
            end
            PAT_XOR: begin
                r_c = COLOR_BITS'(xor_p2);
                g_c = COLOR_BITS'(xor_p4);
                b_c = COLOR_BITS'(xor_p3);
            end
            PAT_BORDER: begin
                r_c = border ? ONES : '0;
            end
            default: begin
                r_c = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de          <= 1'b0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            de          <= 1'b0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            de          <= de_c;
            hsync       <= hs_act ? SYNC_ACT : SYNC_IDLE;
            vsync       <= vs_act ? SYNC_ACT : SYNC_IDLE;
            red         <= de_c ? r_c : '0;
            green       <= de_c ? g_c : '0;
            blue        <= de_c ? b_c : '0;
            pos_x       <= h;
            pos_y       <= v;
            frame_start <= at_origin;
        end
    end

    assign video_data = {de, vsync, hsync, blue, green, red};

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Directed bench: stimulus pushes cycle-tagged expectations, a negedge monitor pops and compares them.
module tb_lcd_timing_pattern_gen;

    localparam int CB = 6;
    localparam int CW = 12;
    localparam int FRAME = 98;
    localparam int LINE  = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [2:0]    pattern_sel;

    logic          hsync, vsync, de, frame_start;
    logic [CB-1:0] red, green, blue;
    logic [CW-1:0] pos_x, pos_y;
    logic [7:0]    frame_cnt;
    logic [3*CB+2:0] video_data;

    logic          hsync2, vsync2, de2, frame_start2;
    logic [CB-1:0] red2, green2, blue2;
    logic [CW-1:0] pos_x2, pos_y2;
    logic [7:0]    frame_cnt2;
    logic [3*CB+2:0] video_data2;

    always #5 clk = ~clk;

    lcd_timing_pattern_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .COLOR_BITS(CB), .CNT_W(CW), .CHECK_LOG2(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
        .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue),
        .pos_x(pos_x), .pos_y(pos_y), .frame_cnt(frame_cnt),
        .frame_start(frame_start), .video_data(video_data)
    );

    lcd_timing_pattern_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .COLOR_BITS(CB), .CNT_W(CW), .CHECK_LOG2(1)
    ) dut_pol (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
        .hsync(hsync2), .vsync(vsync2), .de(de2),
        .red(red2), .green(green2), .blue(blue2),
        .pos_x(pos_x2), .pos_y(pos_y2), .frame_cnt(frame_cnt2),
        .frame_start(frame_start2), .video_data(video_data2)
    );

    typedef struct {
        int cyc;
        int fld;
        int val;
    } exp_t;

    exp_t  sb[$];
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    int    base = 0;
    string fnames [0:12] = '{"de", "hsync", "vsync", "red", "green", "blue", "pos_x", "pos_y",
                             "frame_start", "frame_cnt", "hsync_pol1", "vsync_pol1", "video_data"};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endfunction

    function automatic int get_field(input int id);
        case (id)
            0:       return int'(de);
            1:       return int'(hsync);
            2:       return int'(vsync);
            3:       return int'(red);
            4:       return int'(green);
            5:       return int'(blue);
            6:       return int'(pos_x);
            7:       return int'(pos_y);
            8:       return int'(frame_start);
            9:       return int'(frame_cnt);
            10:      return int'(hsync2);
            11:      return int'(vsync2);
            12:      return int'(video_data);
            default: return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk($sformatf("%s@cyc%0d", fnames[sb[i].fld], cyc), get_field(sb[i].fld), sb[i].val);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_%s@cyc%0d: never sampled, expected %0d",
                         fnames[sb[i].fld], sb[i].cyc, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    function automatic int pc(input int f, input int x, input int y);
        return base + f * FRAME + y * LINE + x;
    endfunction

    task automatic ex(input int c, input int f, input int v);
        exp_t e;
        e.cyc = c;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic ex_rgb(input int c, input int r, input int g, input int b);
        ex(c, 3, r);
        ex(c, 4, g);
        ex(c, 5, b);
    endtask

    task automatic ex_reset(input int c);
        ex(c, 0, 0);
        ex(c, 1, 1);
        ex(c, 2, 1);
        ex(c, 10, 0);
        ex(c, 11, 0);
        ex(c, 3, 0);
        ex(c, 6, 0);
        ex(c, 7, 0);
        ex(c, 8, 0);
        ex(c, 9, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int de_cnt;
        int d0;
        int r2;
        rst = 1'b0;
        en = 1'b0;
        pattern_sel = 3'd0;
        #1 rst = 1'b1;
        step();
        ex_reset(cyc);
        step();
        rst = 1'b0;
        en = 1'b1;
        base = cyc + 1;

        // Solid red: timing windows, alignment, frame period
        ex(pc(0,0,0), 8, 1);  ex(pc(0,0,0), 0, 1);  ex_rgb(pc(0,0,0), 63, 0, 0);
        ex(pc(0,0,0), 6, 0);  ex(pc(0,0,0), 7, 0);  ex(pc(0,0,0), 9, 0);
        ex(pc(0,1,0), 8, 0);
        ex(pc(0,7,0), 0, 1);  ex(pc(0,8,0), 0, 0);  ex(pc(0,8,0), 3, 0);
        ex(pc(0,9,0), 1, 1);  ex(pc(0,10,0), 1, 0); ex(pc(0,10,0), 10, 1);
        ex(pc(0,11,1), 1, 0); ex(pc(0,12,0), 1, 1); ex(pc(0,12,0), 10, 0);
        ex(pc(0,3,3), 0, 1);  ex(pc(0,3,3), 6, 3);  ex(pc(0,3,3), 7, 3);
        ex(pc(0,3,4), 0, 0);
        ex(pc(0,0,4), 2, 1);  ex(pc(0,0,5), 2, 0);  ex(pc(0,0,5), 11, 1);
        ex(pc(0,13,5), 2, 0); ex(pc(0,0,6), 2, 1);  ex(pc(0,0,6), 11, 0);
        ex(pc(0,2,1), 12, 1835071);
        ex(pc(0,13,6), 8, 0); ex(pc(1,0,0), 8, 1);  ex(pc(1,0,0), 9, 1);
        ex_rgb(pc(1,0,3), 63, 0, 0);
        // Colour bars in frame 2, selected mid-frame 1
        ex(pc(2,0,0), 8, 1);  ex(pc(2,0,0), 9, 2);
        ex_rgb(pc(2,0,0), 63, 63, 63);
        ex_rgb(pc(2,1,0), 63, 63, 0);
        ex_rgb(pc(2,5,0), 63, 0, 0);
        ex_rgb(pc(2,7,0), 0, 0, 0);
        ex_rgb(pc(2,2,1), 0, 63, 63);
        ex_rgb(pc(2,6,2), 0, 0, 63);
        // Grey ramp in frame 3
        ex_rgb(pc(3,5,1), 5, 5, 5);
        ex_rgb(pc(3,7,0), 7, 7, 7);
        ex(pc(3,9,0), 3, 0);
        // Border in frame 4
        ex_rgb(pc(4,0,1), 63, 0, 0);
        ex_rgb(pc(4,3,1), 0, 0, 0);
        ex_rgb(pc(4,7,2), 63, 0, 0);
        ex_rgb(pc(4,3,3), 63, 0, 0);
        ex_rgb(pc(4,3,0), 63, 0, 0);
        // Pattern 6 is black in frame 5
        ex_rgb(pc(5,3,0), 0, 0, 0);
        ex(pc(5,3,0), 0, 1);

        de_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            wait_cyc(base + i);
            if (de) de_cnt++;
        end
        chk("de_count_frame0", de_cnt, 32);

        wait_cyc(pc(1,5,2)); pattern_sel = 3'd1;
        wait_cyc(pc(2,5,1)); pattern_sel = 3'd2;
        wait_cyc(pc(3,5,2)); pattern_sel = 3'd5;
        wait_cyc(pc(4,5,2)); pattern_sel = 3'd6;

        // Mid-line reset, then scrolling XOR from a clean start
        wait_cyc(pc(5,3,1));
        rst = 1'b1;
        pattern_sel = 3'd4;
        ex_reset(cyc);
        step();
        rst = 1'b0;
        base = cyc + 1;
        ex(pc(0,0,0), 8, 1);  ex_rgb(pc(0,0,0), 0, 0, 0);
        ex_rgb(pc(0,1,0), 2, 4, 3);  ex(pc(0,1,0), 9, 0);
        ex_rgb(pc(0,2,1), 6, 12, 9);
        ex(pc(1,0,0), 8, 1);  ex(pc(1,0,0), 9, 1);  ex_rgb(pc(1,0,0), 0, 0, 0);
        ex_rgb(pc(1,1,0), 62, 60, 61);
        ex_rgb(pc(2,1,0), 2, 4, 3);  ex(pc(2,1,0), 9, 2);
        ex_rgb(pc(2,2,0), 60, 56, 58);

        // Disable mid-line 2 of frame 2, then re-enable
        d0 = pc(2,4,2);
        wait_cyc(d0);
        en = 1'b0;
        ex(d0+1, 0, 0); ex(d0+1, 3, 0); ex(d0+1, 8, 0); ex(d0+1, 1, 1);
        ex(d0+4, 0, 0); ex(d0+4, 9, 2); ex(d0+4, 2, 1);
        wait_cyc(d0 + 5);
        en = 1'b1;
        ex(d0+6, 8, 1); ex(d0+6, 0, 1); ex(d0+6, 6, 0); ex(d0+6, 7, 0);
        ex_rgb(d0+7, 2, 4, 3); ex(d0+7, 6, 1); ex(d0+7, 9, 2);

        // Reset mid-line with checkerboard selected
        r2 = d0 + 6 + LINE + 3;
        wait_cyc(r2);
        rst = 1'b1;
        pattern_sel = 3'd3;
        ex_reset(cyc);
        step();
        rst = 1'b0;
        base = cyc + 1;
        ex(pc(0,0,0), 8, 1);  ex_rgb(pc(0,0,0), 0, 0, 0);
        ex_rgb(pc(0,2,0), 63, 63, 63);
        ex_rgb(pc(0,3,1), 63, 63, 63);
        ex_rgb(pc(0,1,2), 63, 63, 63);
        ex_rgb(pc(0,2,2), 0, 0, 0);  ex(pc(0,2,2), 0, 1);
        ex(pc(1,0,0), 8, 1);  ex(pc(1,0,0), 9, 1);

        wait_cyc(pc(1,0,0) + 3);
        step();
        foreach (sb[i]) begin
            tests++;
            fails++;
            $display("FAIL unchecked_%s@cyc%0d: expected %0d", fnames[sb[i].fld], sb[i].cyc, sb[i].val);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
